// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard
// controller (slave): ID-stage instruction fields in, stall/flush/forward
// controls out. Optional PIPE_HAZARD_PERF_EN adds the performance counters.
interface pipe_hazard_ctrl_if #(
   parameter int STAGES = 5,
   parameter int REG_AW = 5
);
   localparam int D    = STAGES - 2;
   localparam int FW_W = (D > 1) ? $clog2(D) : 1;

   logic              start_i;
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs_i;
   logic [REG_AW-1:0] id_rt_i;
   logic              id_rt_used_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_regwrite_i;
   logic              id_memread_i;
   logic              flush_i;
   logic              pc_write_o;
   logic              ifid_write_o;
   logic              ifid_flush_o;
   logic              bubble_o;
   logic [FW_W-1:0]   fwd_a_o;
   logic [FW_W-1:0]   fwd_b_o;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0]       stall_cnt_o;
   logic [31:0]       flush_cnt_o;
`endif

   modport master (
      output start_i, id_valid_i, id_rs_i, id_rt_i, id_rt_used_i, id_rd_i,
             id_regwrite_i, id_memread_i, flush_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, fwd_a_o, fwd_b_o
`ifdef PIPE_HAZARD_PERF_EN
      , input stall_cnt_o, flush_cnt_o
`endif
   );

   modport slave (
      input  start_i, id_valid_i, id_rs_i, id_rt_i, id_rt_used_i, id_rd_i,
             id_regwrite_i, id_memread_i, flush_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, fwd_a_o, fwd_b_o
`ifdef PIPE_HAZARD_PERF_EN
      , output stall_cnt_o, flush_cnt_o
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised hazard / forwarding / flush controller for the in-order MIPS
// pipeline. Tracks D = STAGES-2 in-flight instructions (entry 0 = EX,
// entry D-1 = WB), raises load-use stalls, resolves EX forwarding and applies
// branch flushes. Define PIPE_HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int STAGES   = 5,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input logic             clk_i,
   input logic             rst_i,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int D    = STAGES - 2;
   localparam int FW_W = (D > 1) ? $clog2(D) : 1;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } entry_t;

   entry_t            ent [D];
   logic [REG_AW-1:0] e0_rs;
   logic [REG_AW-1:0] e0_rt;
   logic              e0_rt_used;

   logic              stall;
   logic              issue;
   logic [FW_W-1:0]   fwd_a;
   logic [FW_W-1:0]   fwd_b;

   function automatic logic is_prod(input entry_t e);
      return e.valid & e.regwrite & (e.rd != '0);
   endfunction

   // Load-use detection: a load still too young to forward blocks the ID instruction.
   always_comb begin
      // NOTE: default first so every path assigns stall and no latch is inferred.
      stall = 1'b0;
      if (bus.id_valid_i && !rst_i) begin
         for (int k = 0; k < LOAD_LAT; k++) begin
            if (is_prod(ent[k]) && ent[k].memread &&
                (ent[k].rd == bus.id_rs_i ||
                 (bus.id_rt_used_i && ent[k].rd == bus.id_rt_i)))
               stall = 1'b1;
         end
      end
   end

   // Forward select: walk oldest to youngest so the youngest matching producer
   // decides; a matching load whose data is not ready yet yields 0.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      if (ent[0].valid) begin
         for (int k = D - 1; k >= 1; k--) begin
            if (is_prod(ent[k]) && ent[k].rd == e0_rs)
               fwd_a = (ent[k].memread && k < 1 + LOAD_LAT) ? '0 : FW_W'(k);
            if (e0_rt_used && is_prod(ent[k]) && ent[k].rd == e0_rt)
               fwd_b = (ent[k].memread && k < 1 + LOAD_LAT) ? '0 : FW_W'(k);
         end
      end
   end

   assign issue = bus.id_valid_i & ~stall & ~bus.flush_i;

   // Tracker shift register: advances only while the pipeline runs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the tracker is control state, so every entry is cleared on reset.
         for (int k = 0; k < D; k++) ent[k] <= '0;
         e0_rs      <= '0;
         e0_rt      <= '0;
         e0_rt_used <= 1'b0;
      end else if (bus.start_i) begin
         // NOTE: non-blocking so each entry takes its neighbour's pre-edge value.
         for (int k = D - 1; k >= 1; k--) ent[k] <= ent[k-1];
         if (issue) begin
            ent[0]     <= '{valid: 1'b1, rd: bus.id_rd_i,
                            regwrite: bus.id_regwrite_i, memread: bus.id_memread_i};
            e0_rs      <= bus.id_rs_i;
            e0_rt      <= bus.id_rt_i;
            e0_rt_used <= bus.id_rt_used_i;
         end else begin
            ent[0]     <= '0;
            e0_rs      <= '0;
            e0_rt      <= '0;
            e0_rt_used <= 1'b0;
         end
      end
   end

   assign bus.pc_write_o   = bus.start_i & (~stall | bus.flush_i);
   assign bus.ifid_write_o = bus.start_i & ~stall;
   assign bus.ifid_flush_o = bus.start_i & bus.flush_i;
   assign bus.bubble_o     = bus.start_i & (stall | bus.flush_i) & ~rst_i;
   assign bus.fwd_a_o      = fwd_a;
   assign bus.fwd_b_o      = fwd_b;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Saturating event counters; a flush cycle is not counted as a stall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.start_i && stall && !bus.flush_i && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         if (bus.start_i && bus.flush_i && flush_cnt != '1)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default 5-stage instance and a
// 7-stage / LOAD_LAT=3 instance share clock and reset. Counter checks are
// compiled in when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.STAGES(5), .REG_AW(5)) a ();
   pipe_hazard_ctrl_if #(.STAGES(7), .REG_AW(5)) b ();

   pipe_hazard_ctrl #(.STAGES(5), .REG_AW(5), .LOAD_LAT(1)) dut5 (
      .clk_i(clk), .rst_i(rst), .bus(a.slave));
   pipe_hazard_ctrl #(.STAGES(7), .REG_AW(5), .LOAD_LAT(3)) dut7 (
      .clk_i(clk), .rst_i(rst), .bus(b.slave));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ru, input logic [4:0] rd, input logic rw, input logic mr);
      a.id_valid_i = v; a.id_rs_i = rs; a.id_rt_i = rt; a.id_rt_used_i = ru;
      a.id_rd_i = rd; a.id_regwrite_i = rw; a.id_memread_i = mr;
   endtask

   task automatic set_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ru, input logic [4:0] rd, input logic rw, input logic mr);
      b.id_valid_i = v; b.id_rs_i = rs; b.id_rt_i = rt; b.id_rt_used_i = ru;
      b.id_rd_i = rd; b.id_regwrite_i = rw; b.id_memread_i = mr;
   endtask

   task automatic apply_reset;
      a.start_i = 1'b1; a.flush_i = 1'b0; set_a(0, 0, 0, 0, 0, 0, 0);
      b.start_i = 1'b1; b.flush_i = 1'b0; set_b(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      a.start_i = 1'b1; a.flush_i = 1'b1; set_a(0, 0, 0, 0, 0, 0, 0);
      b.start_i = 1'b1; b.flush_i = 1'b0; set_b(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (a.pc_write_o !== 1'b1) begin errors++; $display("FAIL rst_pc_write: got %b want 1", a.pc_write_o); end
      checks++; if (a.ifid_write_o !== 1'b1) begin errors++; $display("FAIL rst_ifid_write: got %b want 1", a.ifid_write_o); end
      checks++; if (a.ifid_flush_o !== 1'b1) begin errors++; $display("FAIL rst_ifid_flush: got %b want 1", a.ifid_flush_o); end
      checks++; if (a.bubble_o !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b want 0", a.bubble_o); end
      checks++; if (a.fwd_a_o !== 2'd0 || a.fwd_b_o !== 2'd0) begin errors++; $display("FAIL rst_fwd: got %0d/%0d want 0/0", a.fwd_a_o, a.fwd_b_o); end
      a.start_i = 1'b0;
      #1;
      checks++; if (a.pc_write_o !== 1'b0 || a.ifid_flush_o !== 1'b0) begin errors++; $display("FAIL rst_start0: got pc=%b fl=%b want 0/0", a.pc_write_o, a.ifid_flush_o); end
      a.flush_i = 1'b0;
      apply_reset();
   endtask

   task automatic test_load_use;
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd2, 1, 1);              // lw $2
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b0) begin errors++; $display("FAIL lu_lw_bubble: got %b want 0", a.bubble_o); end
      tick();
      set_a(1, 5'd2, 5'd4, 1, 5'd3, 1, 0);              // add $3,$2,$4
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b1 || a.pc_write_o !== 1'b0 || a.ifid_write_o !== 1'b0)
         begin errors++; $display("FAIL lu_stall: got bub=%b pc=%b ifw=%b want 1/0/0", a.bubble_o, a.pc_write_o, a.ifid_write_o); end
      tick();
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b0 || a.pc_write_o !== 1'b1 || a.ifid_write_o !== 1'b1)
         begin errors++; $display("FAIL lu_release: got bub=%b pc=%b ifw=%b want 0/1/1", a.bubble_o, a.pc_write_o, a.ifid_write_o); end
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd2) begin errors++; $display("FAIL lu_fwd_a: got %0d want 2", a.fwd_a_o); end
      checks++; if (a.fwd_b_o !== 2'd0) begin errors++; $display("FAIL lu_fwd_b: got %0d want 0", a.fwd_b_o); end
`ifdef PIPE_HAZARD_PERF_EN
      checks++; if (a.stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", a.stall_cnt_o); end
`endif
   endtask

   task automatic test_back_to_back;
      apply_reset();
      set_a(1, 5'd1, 5'd1, 1, 5'd5, 1, 0);              // add $5,$1,$1
      tick();
      set_a(1, 5'd5, 5'd5, 1, 5'd6, 1, 0);              // sub $6,$5,$5
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b0) begin errors++; $display("FAIL b2b_no_stall: got %b want 0", a.bubble_o); end
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd1 || a.fwd_b_o !== 2'd1) begin errors++; $display("FAIL b2b_fwd: got %0d/%0d want 1/1", a.fwd_a_o, a.fwd_b_o); end
   endtask

   task automatic test_youngest;
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd5, 1, 0);              // add $5
      tick();
      set_a(1, 5'd2, 5'd0, 0, 5'd5, 1, 0);              // add $5
      tick();
      set_a(1, 5'd5, 5'd0, 1, 5'd7, 1, 0);              // or $7,$5,$0
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd1) begin errors++; $display("FAIL young_fwd_a: got %0d want 1", a.fwd_a_o); end
      checks++; if (a.fwd_b_o !== 2'd0) begin errors++; $display("FAIL young_fwd_b: got %0d want 0", a.fwd_b_o); end
      tick();
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd0) begin errors++; $display("FAIL young_invalid_e0: got %0d want 0", a.fwd_a_o); end
   endtask

   task automatic test_wb_retire;
      // Producer in WB is forwarded from entry 2.
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd10, 1, 0);             // add $10
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      tick();
      set_a(1, 5'd3, 5'd10, 1, 5'd11, 1, 0);            // user reads $10 on rt
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (a.fwd_b_o !== 2'd2) begin errors++; $display("FAIL wb_fwd_b: got %0d want 2", a.fwd_b_o); end
      // One more slot of distance: producer has retired, no forwarding.
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd10, 1, 0);
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      set_a(1, 5'd10, 5'd0, 0, 5'd11, 1, 0);
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd0) begin errors++; $display("FAIL retired_fwd_a: got %0d want 0", a.fwd_a_o); end
   endtask

   task automatic test_reg_zero;
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd0, 1, 1);              // lw $0
      tick();
      set_a(1, 5'd0, 5'd0, 1, 5'd3, 1, 0);              // add $3,$0,$0
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b0) begin errors++; $display("FAIL r0_no_stall: got %b want 0", a.bubble_o); end
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd0 || a.fwd_b_o !== 2'd0) begin errors++; $display("FAIL r0_no_fwd: got %0d/%0d want 0/0", a.fwd_a_o, a.fwd_b_o); end
   endtask

   task automatic test_flush_stall;
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd2, 1, 1);              // lw $2
      tick();
      set_a(1, 5'd2, 5'd0, 0, 5'd7, 1, 1);              // lw $7,0($2): stalls
      a.flush_i = 1'b1;
      @(negedge clk);
      checks++; if (a.pc_write_o !== 1'b1 || a.ifid_flush_o !== 1'b1 || a.bubble_o !== 1'b1)
         begin errors++; $display("FAIL fs_ctrl: got pc=%b fl=%b bub=%b want 1/1/1", a.pc_write_o, a.ifid_flush_o, a.bubble_o); end
      checks++; if (a.ifid_write_o !== 1'b0) begin errors++; $display("FAIL fs_ifid_write: got %b want 0", a.ifid_write_o); end
      tick();
      a.flush_i = 1'b0;
      set_a(1, 5'd7, 5'd7, 1, 5'd8, 1, 0);              // would stall only if lw $7 had issued
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b0) begin errors++; $display("FAIL fs_discarded: got %b want 0", a.bubble_o); end
`ifdef PIPE_HAZARD_PERF_EN
      checks++; if (a.flush_cnt_o !== 32'd1 || a.stall_cnt_o !== 32'd0)
         begin errors++; $display("FAIL fs_counters: got fl=%0d st=%0d want 1/0", a.flush_cnt_o, a.stall_cnt_o); end
`endif
      tick();
      set_a(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_start_hold;
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd2, 1, 1);              // lw $2
      tick();
      a.start_i = 1'b0; a.flush_i = 1'b1;
      set_a(1, 5'd2, 5'd0, 0, 5'd3, 1, 0);
      @(negedge clk);
      checks++; if (a.pc_write_o !== 1'b0 || a.ifid_write_o !== 1'b0 || a.bubble_o !== 1'b0 || a.ifid_flush_o !== 1'b0)
         begin errors++; $display("FAIL hold_outputs: got pc=%b ifw=%b bub=%b fl=%b want 0/0/0/0", a.pc_write_o, a.ifid_write_o, a.bubble_o, a.ifid_flush_o); end
      tick();
      a.start_i = 1'b1; a.flush_i = 1'b0;
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b1) begin errors++; $display("FAIL hold_state_kept: got %b want 1", a.bubble_o); end
      tick();
      @(negedge clk);
      checks++; if (a.bubble_o !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", a.bubble_o); end
      set_a(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_stall;
      apply_reset();
      set_a(1, 5'd1, 5'd0, 0, 5'd5, 1, 0);              // add $5
      tick();
      set_a(1, 5'd5, 5'd0, 0, 5'd2, 1, 1);              // lw $2,0($5)
      tick();
      set_a(1, 5'd2, 5'd4, 1, 5'd3, 1, 0);              // add $3,$2,$4
      @(negedge clk);
      checks++; if (a.fwd_a_o !== 2'd1 || a.bubble_o !== 1'b1)
         begin errors++; $display("FAIL mid_pre: got fwd=%0d bub=%b want 1/1", a.fwd_a_o, a.bubble_o); end
      #1 rst = 1'b1;
      #1;
      checks++; if (a.fwd_a_o !== 2'd0 || a.fwd_b_o !== 2'd0 || a.bubble_o !== 1'b0)
         begin errors++; $display("FAIL mid_rst: got fwd=%0d/%0d bub=%b want 0/0/0", a.fwd_a_o, a.fwd_b_o, a.bubble_o); end
      checks++; if (a.pc_write_o !== 1'b1 || a.ifid_write_o !== 1'b1)
         begin errors++; $display("FAIL mid_rst_we: got pc=%b ifw=%b want 1/1", a.pc_write_o, a.ifid_write_o); end
`ifdef PIPE_HAZARD_PERF_EN
      checks++; if (a.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", a.stall_cnt_o); end
`endif
      @(negedge clk); rst = 1'b0;
      set_a(0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_long_load;
      apply_reset();
      set_b(1, 5'd1, 5'd0, 0, 5'd8, 1, 1);              // lw $8
      tick();
      set_b(1, 5'd8, 5'd9, 0, 5'd9, 1, 0);              // addi $9,$8,1
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (b.bubble_o !== 1'b1) begin errors++; $display("FAIL ll_bubble_%0d: got %b want 1", i, b.bubble_o); end
         tick();
      end
      @(negedge clk);
      checks++; if (b.bubble_o !== 1'b0 || b.ifid_write_o !== 1'b1)
         begin errors++; $display("FAIL ll_release: got bub=%b ifw=%b want 0/1", b.bubble_o, b.ifid_write_o); end
      tick();
      set_b(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (b.fwd_a_o !== 3'd4) begin errors++; $display("FAIL ll_fwd_a: got %0d want 4", b.fwd_a_o); end
      checks++; if (b.fwd_b_o !== 3'd0) begin errors++; $display("FAIL ll_fwd_b: got %0d want 0", b.fwd_b_o); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_back_to_back();
      test_youngest();
      test_wb_retire();
      test_reg_zero();
      test_flush_stall();
      test_start_hold();
      test_reset_mid_stall();
      test_long_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order MIPS pipeline.
- Replaces the fixed 5-stage HazardDetection / ForwardUnit / Flush trio with one block.
- Tracks in-flight destination registers over a configurable number of post-ID stages and a configurable load latency.
- Produces PC/IFID write enables, the IDEX bubble, the IFID flush, and EX-stage forwarding selects.

Parameters:
- STAGES, 5: total pipeline stages. Tracked entries D = STAGES-2: entry 0 = EX, entry D-1 = WB. Legal range 4..8.
- REG_AW, 5: register address width.
- LOAD_LAT, 1: extra stages after EX before load data can be forwarded. Legal range 1..D-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  pipeline run enable; 0 freezes all state.
- id_valid_i  in  1  IF/ID holds a real instruction.
- id_rs_i  in  REG_AW  ID source A.
- id_rt_i  in  REG_AW  ID source B.
- id_rt_used_i  in  1  source B is actually read (R-type, store, beq).
- id_rd_i  in  REG_AW  ID destination, already RegDst-selected.
- id_regwrite_i  in  1  ID instruction writes a register.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  taken branch or jump resolved this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  zero the IF/ID instruction.
- bubble_o  out  1  force zero control into IDEX.
- fwd_a_o  out  clog2(D)  EX operand A source: 0 = IDEX register value, k = result of entry k.
- fwd_b_o  out  clog2(D)  EX operand B source, same encoding.

Behaviour:
- Tracker state:
  - D entries, each {valid, rd, regwrite, memread}. Entry 0 additionally holds rs, rt, rt_used.
  - An entry is a producer when valid & regwrite & rd != 0.
- Advance: on each rising clk_i with start_i=1:
  - entry k+1 <= entry k.
  - Entry D-1 retires and is dropped.
  - Entry 0 loads the ID fields if issue = id_valid_i & ~stall & ~flush_i; otherwise entry 0 valid <= 0.
- start_i=0: all entries hold; pc_write_o = ifid_write_o = 0; bubble_o = 0.
- Load-use stall (combinational):
  - stall = 1 if id_valid_i and some entry k < LOAD_LAT is a load producer with rd == id_rs_i, or with rd == id_rt_i & id_rt_used_i.
  - Default LOAD_LAT=1: stall only on a load in EX.
- Output equations:
  - pc_write_o = start_i & (~stall | flush_i).
  - ifid_write_o = start_i & ~stall.
  - ifid_flush_o = start_i & flush_i.
  - bubble_o = start_i & (stall | flush_i).
- Flush vs stall: flush wins. PC is redirected, IF/ID is zeroed, a bubble enters EX, and the stalled instruction is discarded.
- Forwarding (combinational, from entry 0 sources):
  - Search entries 1..D-1 for a producer with rd == entry0.rs; the youngest (lowest k) wins.
  - A load producer qualifies only if k >= 1+LOAD_LAT.
  - An older qualifying match behind a younger non-qualifying load match is not used; this case cannot arise because the stall prevents it.
  - rt uses the same search, gated by entry0.rt_used.
  - Outputs 0 when entry 0 is invalid or no match.
- Register 0 never stalls and never forwards.
- Register file must be write-first. A producer that retired from entry D-1 is not forwarded.
- Reset, asynchronous:
  - All entries valid=0, fields 0.
  - Outputs: fwd_a_o = fwd_b_o = 0, bubble_o = 0, ifid_flush_o = flush_i & start_i, pc_write_o = ifid_write_o = start_i.
  - Reset mid-stall clears the stall immediately.
- Latency:
  - Stall, flush and forward decisions are zero-cycle (same cycle).
  - The tracker reflects an issued instruction from the next edge.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - Each increments on rising clk_i while start_i & stall & ~flush_i, or start_i & flush_i, respectively.
  - Both saturate at 32'hFFFFFFFF and clear on rst_i.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- lw $2 issued, next cycle ID = add $3,$2,$4 (rt_used=1), defaults:
  - bubble_o=1, pc_write_o=0, ifid_write_o=0 for exactly 1 cycle.
  - Next cycle the add enters EX with fwd_a_o=2 (WB).
- add $5,$1,$1 then sub $6,$5,$5 back-to-back: no stall; sub in EX sees fwd_a_o=1, fwd_b_o=1.
- add $5 and add $5 in consecutive slots, then or $7,$5,$0: fwd_a_o=1 (youngest), fwd_b_o=0.
- STAGES=7, LOAD_LAT=3, lw $8 then dependent addi $9,$8,1 (rt_used=0):
  - 3 bubble cycles.
  - Then fwd_a_o=4.
- Stall and flush_i=1 in the same cycle: pc_write_o=1, ifid_flush_o=1, bubble_o=1; tracker entry 0 invalid next cycle.
- rst_i pulsed high during a stall with start_i=1: all fwd=0, bubble_o=0 immediately. With PIPE_HAZARD_PERF_EN, stall_cnt_o=0.
